// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-master to 1-slave memory arbiter with a locked grant, burst reads and
// responses routed back to the owning master. Fixed-priority or round-robin arbitration.
module mem_arbiter_rr #(
  parameter int NUM_M   = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR_MODE = 1
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  input  logic [NUM_M-1:0]    m_valid_i,
  output logic [NUM_M-1:0]    m_ready_o,
  input  logic [NUM_M-1:0]    m_write_i,
  input  logic [NUM_M*AW-1:0] m_addr_i,
  input  logic [NUM_M*DW-1:0] m_wdata_i,
  input  logic [NUM_M*2-1:0]  m_mask_i,
  input  logic [NUM_M*8-1:0]  m_len_i,
  input  logic [NUM_M-1:0]    m_rsign_i,
  output logic [NUM_M-1:0]    m_rvalid_o,
  output logic [NUM_M-1:0]    m_rlast_o,
  output logic [NUM_M-1:0]    m_bvalid_o,
  output logic [NUM_M-1:0]    m_err_o,
  output logic [DW-1:0]       m_rdata_o,
  output logic                s_valid_o,
  input  logic                s_ready_i,
  output logic                s_write_o,
  output logic [AW-1:0]       s_addr_o,
  output logic [DW-1:0]       s_wdata_o,
  output logic [1:0]          s_mask_o,
  output logic [7:0]          s_len_o,
  output logic                s_rsign_o,
  input  logic                s_rvalid_i,
  input  logic                s_rlast_i,
  input  logic [DW-1:0]       s_rdata_i,
  input  logic                s_bvalid_i,
  input  logic                s_err_i,
  output logic                busy_o
);
  localparam int OW = $clog2(NUM_M);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  state_e         state_q;
  logic [OW-1:0]  owner_q, rr_ptr_q, win;
  logic [7:0]     beat_cnt_q;
  logic           err_sticky_q, found, grant, is_rd, is_wr, last_beat, rlast_bad, rd_err;
  logic [NUM_M-1:0] owner_oh;
  int             cand;
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_M; k++) begin
      cand = (RR_MODE != 0) ? int'(rr_ptr_q) + k : k;
      cand = (cand >= NUM_M) ? cand - NUM_M : cand;
      if (!found && m_valid_i[cand]) begin
        win   = OW'(cand);
        found = 1'b1;
      end
    end
  end
  // reset_ni gates the grant so m_ready stays low while reset is held
  assign grant      = reset_ni && (state_q == IDLE) && found;
  assign m_ready_o  = grant ? (NUM_M'(1) << win) : '0;
  assign owner_oh   = NUM_M'(1) << owner_q;
  assign is_rd      = (state_q == RESP) && !s_write_o && s_rvalid_i;
  assign is_wr      = (state_q == RESP) && s_write_o && s_bvalid_i;
  assign last_beat  = beat_cnt_q == s_len_o;
  assign rlast_bad  = s_rlast_i != last_beat;
  // a misplaced rlast anywhere in the burst is reported on the final beat
  assign rd_err     = s_err_i || (last_beat && (err_sticky_q || rlast_bad));
  assign m_rvalid_o = is_rd ? owner_oh : '0;
  assign m_rlast_o  = (is_rd && last_beat) ? owner_oh : '0;
  assign m_bvalid_o = is_wr ? owner_oh : '0;
  assign m_err_o    = ((is_rd && rd_err) || (is_wr && s_err_i)) ? owner_oh : '0;
  assign m_rdata_o  = is_rd ? s_rdata_i : '0;
  assign s_valid_o  = state_q == REQ;
  assign busy_o     = state_q != IDLE;
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      err_sticky_q <= 1'b0;
      s_write_o    <= 1'b0;
      s_addr_o     <= '0;
      s_wdata_o    <= '0;
      s_mask_o     <= '0;
      s_len_o      <= '0;
      s_rsign_o    <= 1'b0;
    end else begin
      if (grant) begin
        state_q   <= REQ;
        owner_q   <= win;
        s_write_o <= m_write_i[win];
        s_addr_o  <= m_addr_i[win*AW +: AW];
        s_wdata_o <= m_wdata_i[win*DW +: DW];
        s_mask_o  <= m_mask_i[win*2 +: 2];
        s_len_o   <= m_len_i[win*8 +: 8];
        s_rsign_o <= m_rsign_i[win];
        if (RR_MODE != 0) rr_ptr_q <= (win == OW'(NUM_M - 1)) ? '0 : win + 1'b1;
      end
      if (state_q == REQ && s_ready_i) begin
        state_q      <= RESP;
        beat_cnt_q   <= '0;
        err_sticky_q <= 1'b0;
      end
      if (is_rd) begin
        beat_cnt_q   <= beat_cnt_q + 1'b1;
        err_sticky_q <= err_sticky_q || rlast_bad;
        if (last_beat) state_q <= IDLE;
      end
      if (is_wr) state_q <= IDLE;
    end
  end
  a_ready_onehot: assert property (@(posedge clock_i) disable iff (!reset_ni) $onehot0(m_ready_o));
  a_req_stable: assert property (@(posedge clock_i) disable iff (!reset_ni)
    s_valid_o && !s_ready_i |=> s_valid_o && $stable(s_addr_o) && $stable(s_wdata_o));
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed bench for a 2-master fixed-priority and a 4-master round-robin arbiter.
module tb_mem_arbiter_rr;
  logic clk = 1'b0, rst_n;
  always #5 clk = ~clk;
  logic s_ready, s_rvalid, s_rlast, s_bvalid, s_err;
  logic [31:0] s_rdata;
  logic [3:0] r_valid, r_write, r_rsign, r_ready, r_rvalid, r_rlast, r_bvalid, r_err;
  logic [127:0] r_addr, r_wdata;
  logic [7:0] r_mask, r_sl;
  logic [31:0] r_len, r_rdata, r_sa, r_swd;
  logic r_sv, r_sw, r_srs, r_busy;
  logic [1:0] r_sm;
  logic [1:0] f_valid, f_write, f_rsign, f_ready, f_rvalid, f_rlast, f_bvalid, f_err, f_sm;
  logic [63:0] f_addr, f_wdata;
  logic [3:0] f_mask;
  logic [15:0] f_len;
  logic [31:0] f_rdata, f_sa, f_swd;
  logic [7:0] f_sl;
  logic f_sv, f_sw, f_srs, f_busy;
  int n_tests = 0, n_fail = 0;

  mem_arbiter_rr #(.NUM_M(4), .RR_MODE(1)) u_rr (
    .clock_i(clk), .reset_ni(rst_n), .m_valid_i(r_valid), .m_ready_o(r_ready),
    .m_write_i(r_write), .m_addr_i(r_addr), .m_wdata_i(r_wdata), .m_mask_i(r_mask),
    .m_len_i(r_len), .m_rsign_i(r_rsign), .m_rvalid_o(r_rvalid), .m_rlast_o(r_rlast),
    .m_bvalid_o(r_bvalid), .m_err_o(r_err), .m_rdata_o(r_rdata), .s_valid_o(r_sv),
    .s_ready_i(s_ready), .s_write_o(r_sw), .s_addr_o(r_sa), .s_wdata_o(r_swd),
    .s_mask_o(r_sm), .s_len_o(r_sl), .s_rsign_o(r_srs), .s_rvalid_i(s_rvalid),
    .s_rlast_i(s_rlast), .s_rdata_i(s_rdata), .s_bvalid_i(s_bvalid), .s_err_i(s_err),
    .busy_o(r_busy));

  mem_arbiter_rr #(.NUM_M(2), .RR_MODE(0)) u_fp (
    .clock_i(clk), .reset_ni(rst_n), .m_valid_i(f_valid), .m_ready_o(f_ready),
    .m_write_i(f_write), .m_addr_i(f_addr), .m_wdata_i(f_wdata), .m_mask_i(f_mask),
    .m_len_i(f_len), .m_rsign_i(f_rsign), .m_rvalid_o(f_rvalid), .m_rlast_o(f_rlast),
    .m_bvalid_o(f_bvalid), .m_err_o(f_err), .m_rdata_o(f_rdata), .s_valid_o(f_sv),
    .s_ready_i(s_ready), .s_write_o(f_sw), .s_addr_o(f_sa), .s_wdata_o(f_swd),
    .s_mask_o(f_sm), .s_len_o(f_sl), .s_rsign_o(f_srs), .s_rvalid_i(s_rvalid),
    .s_rlast_i(s_rlast), .s_rdata_i(s_rdata), .s_bvalid_i(s_bvalid), .s_err_i(s_err),
    .busy_o(f_busy));

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fp_wr(input int idx);
    logic [1:0] e = 2'b01 << idx;
    #1 chk("fp_grant", f_ready, e);
    tick;
    s_ready = 1'b1;
    #1 chk("fp_req_addr", f_sa, 32'h2000_0000 + 32'(idx * 4));
    tick;
    s_ready = 1'b0;
    s_bvalid = 1'b1;
    #1 chk("fp_bvalid", f_bvalid, e);
    chk("fp_no_regrant", f_ready, 2'b00);
    tick;
    s_bvalid = 1'b0;
  endtask

  task automatic rr_wr(input int idx);
    logic [3:0] e = 4'b0001 << idx;
    #1 chk("rr_grant", r_ready, e);
    chk("rr_idle_busy", r_busy, 1'b0);
    tick;
    s_ready = 1'b1;
    #1 chk("rr_req", {r_sv, r_sa}, {1'b1, 32'h1000 + 32'(idx * 16)});
    tick;
    s_ready = 1'b0;
    s_bvalid = 1'b1;
    #1 chk("rr_bvalid", r_bvalid, e);
    chk("rr_no_grant_resp", r_ready, 4'b0000);
    tick;
    s_bvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    {s_ready, s_rvalid, s_rlast, s_bvalid, s_err, s_rdata} = '0;
    {r_write, r_rsign, r_addr, r_wdata, r_mask, r_len} = '0;
    {f_valid, f_write, f_rsign, f_addr, f_wdata, f_mask, f_len} = '0;
    r_valid = 4'hF;
    #1 chk("rst_ready", r_ready, 4'h0);
    chk("rst_outs", {r_busy, r_sv, r_sa, r_rvalid, r_bvalid, r_err}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    r_valid = 4'h0;
    // fixed priority: master 0 wins while it stays valid
    f_valid = 2'b11;
    f_write = 2'b11;
    f_addr = {32'h2000_0004, 32'h2000_0000};
    repeat (3) fp_wr(0);
    f_valid = 2'b10;
    fp_wr(1);
    f_valid = 2'b00;
    s_rvalid = 1'b1;
    s_rdata = 32'hDEAD_BEEF;
    #1 chk("stray_rvalid", {r_rvalid, f_rvalid, r_rdata}, '0);
    s_rvalid = 1'b0;
    // round robin, all masters valid
    r_valid = 4'hF;
    r_write = 4'hF;
    for (int i = 0; i < 4; i++) r_addr[i*32 +: 32] = 32'h1000 + 32'(i * 16);
    for (int n = 0; n < 5; n++) rr_wr(n % 4);
    // 4-beat read burst on master 2
    r_valid = 4'b0100;
    r_write = 4'h0;
    r_addr[64 +: 32] = 32'h8000_0000;
    r_len[16 +: 8] = 8'd3;
    #1 chk("burst_grant", r_ready, 4'b0100);
    tick;
    r_valid = 4'h0;
    s_ready = 1'b1;
    #1 chk("burst_req", {r_sv, r_sw, r_sa, r_sl}, {1'b1, 1'b0, 32'h8000_0000, 8'd3});
    tick;
    s_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      s_rvalid = 1'b1;
      s_rdata = 32'hA0 + 32'(b);
      s_rlast = (b == 3);
      #1 chk("burst_beat", {r_rvalid, r_rdata, r_rlast, r_err, r_busy},
             {4'b0100, 32'hA0 + 32'(b), (b == 3) ? 4'b0100 : 4'b0000, 4'b0000, 1'b1});
      tick;
    end
    s_rvalid = 1'b0;
    s_rlast = 1'b0;
    #1 chk("burst_busy_fall", r_busy, 1'b0);
    // early rlast on a 2-beat burst, master 3
    r_valid = 4'b1000;
    r_addr[96 +: 32] = 32'h3000;
    r_len[24 +: 8] = 8'd1;
    #1 chk("early_grant", r_ready, 4'b1000);
    tick;
    r_valid = 4'h0;
    s_ready = 1'b1;
    tick;
    s_ready = 1'b0;
    s_rvalid = 1'b1;
    s_rlast = 1'b1;
    s_rdata = 32'hB0;
    #1 chk("early_beat0", {r_err, r_rlast}, {4'b0000, 4'b0000});
    tick;
    s_rlast = 1'b0;
    s_rdata = 32'hB1;
    #1 chk("early_beat1", {r_err, r_rlast}, {4'b1000, 4'b1000});
    tick;
    s_rvalid = 1'b0;
    // delayed s_ready write on master 0, master 1 waiting
    r_valid = 4'b0011;
    r_write = 4'b0001;
    r_addr[0 +: 32] = 32'h4000_0010;
    r_wdata[0 +: 32] = 32'hCAFE_F00D;
    r_mask[1:0] = 2'd2;
    r_addr[32 +: 32] = 32'h5000;
    r_len[8 +: 8] = 8'd3;
    #1 chk("wr_grant", r_ready, 4'b0001);
    tick;
    repeat (5) begin
      #1 chk("wr_hold", {r_sv, r_sa, r_swd, r_sm}, {1'b1, 32'h4000_0010, 32'hCAFE_F00D, 2'd2});
      chk("wr_locked", r_ready, 4'b0000);
      tick;
    end
    s_ready = 1'b1;
    tick;
    s_ready = 1'b0;
    s_bvalid = 1'b1;
    s_err = 1'b1;
    #1 chk("wr_resp", {r_bvalid, r_err}, {4'b0001, 4'b0001});
    tick;
    s_bvalid = 1'b0;
    s_err = 1'b0;
    #1 chk("next_grant", r_ready, 4'b0010);
    tick;
    r_valid = 4'h0;
    s_ready = 1'b1;
    tick;
    s_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      s_rvalid = 1'b1;
      s_rdata = 32'hC0 + 32'(b);
      #1 chk("pre_rst_beat", r_rvalid, 4'b0010);
      tick;
    end
    // asynchronous reset mid-burst
    rst_n = 1'b0;
    #1 chk("mid_rst", {r_rvalid, r_rdata, r_busy, r_sv, r_sa}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    s_rvalid = 1'b0;
    r_valid = 4'b1010;
    #1 chk("post_rst_ptr", r_ready, 4'b0010);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
